// File: rtl/alu_inverse.sv
// Inverse companion to the 4-bit ALU: recovers the other operand from an ALU result.
// Unpack, binary and BCD subtract finish in one cycle; divide runs a multi-cycle restoring loop.
module alu_inverse #(
    parameter int DIV_STEPS = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] S,
    input  logic [7:0] Y,
    input  logic [3:0] B,
    output logic [7:0] Q,
    output logic [3:0] R,
    output logic       err,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t     state;
    logic [3:0] cnt;
    logic [3:0] b_r;
    logic [7:0] quo;
    logic [3:0] rem;

    logic [8:0] bin_diff;
    logic [4:0] lo_diff;
    logic [7:0] bcd_q;
    logic       bcd_err;
    logic [4:0] trial;
    logic       ge;
    logic [4:0] step_rem;
    logic [7:0] step_quo;

    always_comb begin
        bin_diff = {1'b0, Y} - {5'b0, B};

        // A negative low-digit difference borrows ten from the high digit.
        lo_diff = {1'b0, Y[3:0]} - {1'b0, B};
        if (lo_diff[4])
            bcd_q = {Y[7:4] - 4'd1, lo_diff[3:0] + 4'd10};
        else
            bcd_q = {Y[7:4], lo_diff[3:0]};
        bcd_err = (Y[7:4] > 4'd9) || (Y[3:0] > 4'd9) || (B > 4'd9) ||
                  ((Y[7:4] == 4'd0) && lo_diff[4]);

        trial    = {rem, quo[7]};
        ge       = (trial >= {1'b0, b_r});
        step_rem = ge ? (trial - {1'b0, b_r}) : trial;
        step_quo = {quo[6:0], ge};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
            b_r   <= 4'h0;
            quo   <= 8'h00;
            rem   <= 4'h0;
            Q     <= 8'h00;
            R     <= 4'h0;
            err   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy  <= 1'b1;
                        state <= FIN;
                        done  <= 1'b1;
                        case (S)
                            2'b00: begin
                                Q   <= {4'h0, Y[7:4]};
                                R   <= Y[3:0];
                                err <= 1'b0;
                            end
                            2'b01: begin
                                Q   <= bin_diff[7:0];
                                R   <= 4'h0;
                                err <= bin_diff[8];
                            end
                            2'b10: begin
                                Q   <= bcd_err ? 8'h00 : bcd_q;
                                R   <= 4'h0;
                                err <= bcd_err;
                            end
                            default: begin
                                if (B == 4'h0) begin
                                    Q   <= 8'hFF;
                                    R   <= 4'h0;
                                    err <= 1'b1;
                                end else begin
                                    done  <= 1'b0;
                                    state <= CALC;
                                    b_r   <= B;
                                    quo   <= Y;
                                    rem   <= 4'h0;
                                    cnt   <= 4'd0;
                                end
                            end
                        endcase
                    end
                end
                CALC: begin
                    quo <= step_quo;
                    rem <= step_rem[3:0];
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'(DIV_STEPS - 1)) begin
                        Q     <= step_quo;
                        R     <= step_rem[3:0];
                        // Partial remainder overflow would mean a broken divide.
                        err   <= step_rem[4];
                        done  <= 1'b1;
                        state <= FIN;
                    end
                end
                FIN: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_inverse.sv
// Directed bench for alu_inverse: each op with hand-computed results, handshake and reset abort.
module tb_alu_inverse;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [1:0] S;
    logic [7:0] Y;
    logic [3:0] B;
    logic [7:0] Q;
    logic [3:0] R;
    logic       err;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;
    int lat;
    logic saw_done;

    alu_inverse #(.DIV_STEPS(8)) dut (
        .clk(clk), .reset(reset), .start(start), .S(S), .Y(Y), .B(B),
        .Q(Q), .R(R), .err(err), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one start pulse, then wait (bounded) for done; lat counts cycles to done.
    task automatic run(input logic [1:0] s, input logic [7:0] y, input logic [3:0] b,
                       output int l);
        if (done) @(posedge clk);
        @(negedge clk);
        S = s; Y = y; B = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        l = 1;
        while (!done && l < 20) begin
            @(posedge clk); #1;
            l++;
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; S = 2'b00; Y = 8'h00; B = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_q", 32'(Q), 32'h00);
        chk("rst_r", 32'(R), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        @(negedge clk); reset = 1'b0;

        // Unpack
        run(2'b00, 8'hA5, 4'h3, lat);
        chk("unp_lat", 32'(lat), 32'd1);
        chk("unp_q", 32'(Q), 32'h0A);
        chk("unp_r", 32'(R), 32'h5);
        chk("unp_err", 32'(err), 32'h0);
        chk("unp_busy", 32'(busy), 32'h1);
        // start held through the done cycle must be ignored
        S = 2'b00; Y = 8'h77; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("fin_done", 32'(done), 32'h0);
        chk("fin_busy", 32'(busy), 32'h0);
        @(posedge clk); #1;
        chk("fin_ign_busy", 32'(busy), 32'h0);
        chk("fin_ign_q", 32'(Q), 32'h0A);

        // Binary subtract
        run(2'b01, 8'd20, 4'd5, lat);
        chk("sub_lat", 32'(lat), 32'd1);
        chk("sub_q", 32'(Q), 32'd15);
        chk("sub_err", 32'(err), 32'h0);
        run(2'b01, 8'd3, 4'd5, lat);
        chk("subw_q", 32'(Q), 32'hFE);
        chk("subw_r", 32'(R), 32'h0);
        chk("subw_err", 32'(err), 32'h1);

        // BCD subtract
        run(2'b10, 8'h42, 4'h7, lat);
        chk("bcd_lat", 32'(lat), 32'd1);
        chk("bcd_q", 32'(Q), 32'h35);
        chk("bcd_err", 32'(err), 32'h0);
        run(2'b10, 8'h4A, 4'h1, lat);
        chk("bcdinv_q", 32'(Q), 32'h00);
        chk("bcdinv_err", 32'(err), 32'h1);
        run(2'b10, 8'h05, 4'h7, lat);
        chk("bcdneg_q", 32'(Q), 32'h00);
        chk("bcdneg_err", 32'(err), 32'h1);
        run(2'b10, 8'h30, 4'h1, lat);
        chk("bcdbor_q", 32'(Q), 32'h29);
        chk("bcdbor_err", 32'(err), 32'h0);

        // Divide
        run(2'b11, 8'd200, 4'd7, lat);
        chk("div_lat", 32'(lat), 32'd9);
        chk("div_q", 32'(Q), 32'd28);
        chk("div_r", 32'(R), 32'd4);
        chk("div_err", 32'(err), 32'h0);
        run(2'b11, 8'd255, 4'd15, lat);
        chk("div2_lat", 32'(lat), 32'd9);
        chk("div2_q", 32'(Q), 32'd17);
        chk("div2_r", 32'(R), 32'd0);
        run(2'b11, 8'd123, 4'd0, lat);
        chk("div0_lat", 32'(lat), 32'd1);
        chk("div0_q", 32'(Q), 32'hFF);
        chk("div0_r", 32'(R), 32'h0);
        chk("div0_err", 32'(err), 32'h1);

        // Handshake: start pulse and input changes during a divide are ignored
        @(posedge clk);
        @(negedge clk);
        S = 2'b11; Y = 8'd100; B = 4'd9; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        repeat (2) begin @(posedge clk); #1; lat++; end
        @(negedge clk);
        S = 2'b00; Y = 8'h33; B = 4'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; lat++;
        chk("hs_busy", 32'(busy), 32'h1);
        while (!done && lat < 20) begin @(posedge clk); #1; lat++; end
        chk("hs_lat", 32'(lat), 32'd9);
        chk("hs_q", 32'(Q), 32'd11);
        chk("hs_r", 32'(R), 32'd1);
        // back-to-back: start in the cycle after done
        run(2'b00, 8'hC3, 4'h0, lat);
        chk("b2b_lat", 32'(lat), 32'd1);
        chk("b2b_q", 32'(Q), 32'h0C);
        chk("b2b_r", 32'(R), 32'h3);

        // Reset in the 4th cycle of a divide
        @(posedge clk);
        @(negedge clk);
        S = 2'b11; Y = 8'd90; B = 4'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("rmid_q", 32'(Q), 32'h00);
        chk("rmid_r", 32'(R), 32'h0);
        chk("rmid_err", 32'(err), 32'h0);
        chk("rmid_busy", 32'(busy), 32'h0);
        chk("rmid_done", 32'(done), 32'h0);
        @(negedge clk); reset = 1'b0;
        saw_done = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
        end
        chk("rmid_nodone", 32'(saw_done), 32'h0);
        chk("rmid_idle", 32'(busy), 32'h0);
        run(2'b11, 8'd90, 4'd4, lat);
        chk("rdiv_lat", 32'(lat), 32'd9);
        chk("rdiv_q", 32'(Q), 32'd22);
        chk("rdiv_r", 32'(R), 32'd2);
        chk("rdiv_err", 32'(err), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_inverse.md
Name: alu_inverse

Overview:
- Sequential companion that runs the 4-bit ALU operations backwards. It takes an 8-bit ALU-style result Y, a 4-bit operand B and the same 2-bit op select S.
- Recovers the other operand or quotient: unpack for concatenation, subtract for binary and BCD addition, and an iterative restoring divide for multiplication.
- Sits beside the ALU in the datapath and uses a start/busy/done handshake so a multi-cycle divide can share the ALU's result bus.

Parameters:
- DIV_STEPS, 8, number of restoring-divide iterations; equals the Y width and is fixed at 8 for this design.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only while busy=0
- S  input  2  op select: 00 unpack, 01 binary subtract, 10 BCD subtract, 11 divide
- Y  input  8  ALU-style result operand
- B  input  4  known operand
- Q  output  8  primary result (recovered operand or quotient)
- R  output  4  secondary result (low nibble or remainder)
- err  output  1  error flag for the completed operation
- busy  output  1  high while an operation is in flight
- done  output  1  one-cycle pulse when Q/R/err are updated

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: Q=8'h00, R=4'h0, err=0, busy=0, done=0, FSM=IDLE, iteration counter=0.
- Reset mid-operation aborts the operation, returns to IDLE and produces no done pulse.
- FSM states:
  - IDLE: on start=1, latch S, Y, B. Go to CALC if S=11 and B!=0; otherwise go to FIN.
  - CALC: one restoring-divide step per cycle. After DIV_STEPS steps, go to FIN.
  - FIN: commit Q, R, err; done=1 for this cycle only; next state IDLE.
- busy = (state != IDLE), registered.
- start is ignored while busy=1, including the FIN cycle.
- Y, B, S are latched at start; later input changes have no effect on the operation in flight.
- Latency from the cycle start is sampled to the done cycle: 1 cycle for S=00/01/10 and for divide-by-zero; 1+DIV_STEPS = 9 cycles for divide.
- Back-to-back throughput: start may be re-asserted in the cycle after done.
- Q, R, err hold their values between done pulses.
- S=00 unpack: Q={4'h0,Y[7:4]}, R=Y[3:0], err=0.
- S=01 binary subtract:
  - Q=Y-{4'h0,B}, modulo 256; R=4'h0.
  - err=1 when Y<B (borrow); Q still carries the wrapped value.
- S=10 BCD subtract:
  - Y holds two BCD digits (00-99), B holds one BCD digit.
  - Q = packed-BCD value of (Y-B); R=4'h0.
  - err=1 with Q=8'h00 if any input digit >9 or if Y<B.
- S=11 divide:
  - Unsigned Q=Y/B, R=Y%B; 8-bit quotient, 4-bit remainder, using a 5-bit partial remainder internally.
  - B=0: skip CALC; Q=8'hFF, R=4'h0, err=1.
- Simultaneous start and reset: reset wins.

Test Plan:
- Unpack: S=00, Y=8'hA5, start pulse -> done one cycle later with Q=8'h0A, R=4'h5, err=0.
- Binary subtract: S=01, Y=20, B=5 -> Q=15, err=0. Then Y=3, B=5 -> Q=8'hFE, err=1.
- BCD subtract: S=10, Y=8'h42, B=4'h7 -> Q=8'h35, err=0. Then Y=8'h4A, B=1 -> Q=8'h00, err=1. Then Y=8'h05, B=7 -> err=1.
- Divide: S=11, Y=200, B=7 -> busy for 9 cycles, done on cycle 9 with Q=28, R=4. Then Y=255, B=15 -> Q=17, R=0. Then B=0 -> done after 1 cycle, Q=8'hFF, err=1.
- Handshake: during a divide, pulse start with S=00 and change Y/B -> ignored, divide result unchanged. Issue a new start the cycle after done -> accepted.
- Reset mid-divide: assert reset at cycle 4 of a divide -> next cycle all outputs zero, busy=0, no done pulse. A fresh start then completes normally.
